axi_lite_regbank: RTL

//  Parametrised AXI4-Lite slave with an integrated register bank for the AES-128 core control/status map.
//  - Decodes byte addresses into NUM_REGS words and applies byte strobes.
//  - Returns SLVERR for bad accesses and counts them.
//  - Drives flattened register contents to the core; samples read-only status words from the core.

---
 rtl/axi_lite_regbank_if.sv | 27 ++
 rtl/axi_lite_regbank.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between a master and the register-bank slave.
interface axi_lite_regbank_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid, wready;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid, rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave with an integrated control/status register bank for the AES-128 core.
module axi_lite_regbank #(
  parameter int                              DATA_WIDTH = 32,
  parameter int                              ADDR_WIDTH = 7,
  parameter int                              NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  axi_lite_regbank_if.slave              bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_in,
  output logic [7:0]                     err_count
);
  localparam int NB    = DATA_WIDTH/8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - LSB;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                                 aw_held, w_held;
  logic [ADDR_WIDTH-1:0]                aw_addr;
  logic [DATA_WIDTH-1:0]                w_data;
  logic [NB-1:0]                        w_strb;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs, ro_words;
  logic [NUM_REGS-1:0]                  w_sel, r_sel;
  logic                                 w_bad, r_bad, aw_fire, w_fire, ar_fire, commit;
  logic                                 w_err, r_err;
  logic [DATA_WIDTH-1:0]                r_word;
  logic [8:0]                           err_sum;

  assign ro_words    = ro_data_in;
  assign reg_q       = regs;

  assign bus.awready = (w_state == W_IDLE) && !aw_held;
  assign bus.wready  = (w_state == W_IDLE) && !w_held;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_RESP);

  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid  && bus.wready;
  assign ar_fire = bus.arvalid && bus.arready;
  assign commit  = (w_state == W_EXEC) && !w_bad;
  assign w_err   = (w_state == W_EXEC) && w_bad;
  assign r_err   = ar_fire && r_bad;

  // One-hot decode; an empty select means idx is past the end of the bank.
  always_comb begin
    w_sel  = '0;
    r_sel  = '0;
    r_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = (aw_addr[ADDR_WIDTH-1:LSB]    == IDX_W'(i));
      r_sel[i] = (bus.araddr[ADDR_WIDTH-1:LSB] == IDX_W'(i));
      if (r_sel[i]) r_word = RO_MASK[i] ? ro_words[i] : regs[i];
    end
    w_bad = (|aw_addr[LSB-1:0]) || !(|w_sel) || (|(w_sel & RO_MASK));
    r_bad = (|bus.araddr[LSB-1:0]) || !(|r_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if ((aw_held || aw_fire) && (w_held || w_fire)) w_next = W_EXEC;
      W_EXEC:  w_next = W_RESP;
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (bus.arvalid) r_next = R_RESP;
      R_RESP:  if (bus.rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // AW and W are latched independently; flags drop only when the response is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bus.bresp <= OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= bus.awaddr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
      if (w_state == W_EXEC) bus.bresp <= w_bad ? SLVERR : OKAY;
      if (w_state == W_RESP && bus.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= commit ? w_sel : '0;
      if (commit)
        for (int i = 0; i < NUM_REGS; i++)
          for (int k = 0; k < NB; k++)
            if (w_sel[i] && w_strb[k]) regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
    end
  end

  // Captured on the AR edge, so a same-edge commit is not yet visible here.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata <= '0;
      bus.rresp <= OKAY;
    end else if (ar_fire) begin
      bus.rdata <= r_bad ? '0 : r_word;
      bus.rresp <= r_bad ? SLVERR : OKAY;
    end
  end

  assign err_sum = {1'b0, err_count} + 9'(w_err) + 9'(r_err);

  always_ff @(posedge clk) begin
    if (reset)                err_count <= '0;
    else if (err_sum > 9'd255) err_count <= 8'hFF;
    else                      err_count <= err_sum[7:0];
  end
endmodule
